// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the data-memory store buffer.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned SB_ADDR_W = 32;
    localparam int unsigned SB_DATA_W = 32;
    localparam int unsigned SB_PTR_W  = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over pending stores for load forwarding.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = SB_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t              entries_i [DEPTH],
    input  logic [DEPTH-1:0]       valid_i,
    input  logic [PTR_W-1:0]       tail_i,
    input  logic [SB_ADDR_W-1:0]   addr_i,
    output logic                   hit_o,
    output logic [SB_DATA_W-1:0]   data_o
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest slot to youngest so the youngest match overwrites.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PTR_W'(k);
            if (valid_i[idx] && (entries_i[idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO ahead of data memory: loads win the port, stores drain one per idle cycle.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              stall,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    sb_entry_t          entries_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               drain_c;
    logic               accept_c;
    logic [DEPTH-1:0]   valid_c;
    logic [PTR_W-1:0]   off_c;
    logic               hit_c;
    logic [SB_DATA_W-1:0] fwd_data_c;

    // Port arbitration, accept decision and next pointer state.
    always_comb begin
        drain_c  = !reset && !cpu_re && (count_q != '0);
        accept_c = cpu_we && ((count_q < CNT_W'(DEPTH)) || drain_c);
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + CNT_W'(accept_c) - CNT_W'(drain_c);
        if (accept_c) tail_d = tail_q + PTR_W'(1);
        if (drain_c)  head_d = head_q + PTR_W'(1);
    end

    // Slot i is pending when its distance from head is below count.
    always_comb begin
        valid_c = '0;
        off_c   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off_c      = PTR_W'(i) - head_q;
            valid_c[i] = CNT_W'(off_c) < count_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset; validity comes from head/count.
    always_ff @(posedge CLK) begin
        if (accept_c) begin
            entries_q[tail_q] <= '{addr: SB_ADDR_W'(cpu_addr), data: SB_DATA_W'(cpu_wd)};
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries_i (entries_q),
        .valid_i   (valid_c),
        .tail_i    (tail_q),
        .addr_i    (SB_ADDR_W'(cpu_addr)),
        .hit_o     (hit_c),
        .data_o    (fwd_data_c)
    );

    assign mem_WE = drain_c;
    assign mem_A  = drain_c ? ADDR_W'(entries_q[head_q].addr) : cpu_addr;
    assign mem_WD = DATA_W'(entries_q[head_q].data);
    assign cpu_rd = hit_c ? DATA_W'(fwd_data_c) : mem_RD;
    assign stall  = cpu_we && !accept_c && !reset;
    assign empty  = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a word-addressed memory model behind it.
module tb_store_buffer;

    logic        CLK;
    logic        reset;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        stall;
    logic        empty;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic        mem_init;
    logic [31:0] mem [64];

    int vectors;
    int miscompares;

    store_buffer #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .cpu_we   (cpu_we),
        .cpu_re   (cpu_re),
        .cpu_addr (cpu_addr),
        .cpu_wd   (cpu_wd),
        .cpu_rd   (cpu_rd),
        .stall    (stall),
        .empty    (empty),
        .mem_A    (mem_a),
        .mem_WD   (mem_wd),
        .mem_WE   (mem_we),
        .mem_RD   (mem_rd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (mem_we) begin
            mem[mem_a[5:0]] <= mem_wd;
        end
    end

    assign mem_rd = mem[mem_a[5:0]];

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        cpu_we   = we;
        cpu_re   = re;
        cpu_addr = a;
        cpu_wd   = d;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        mem_init = 1'b1;
        set(1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        cyc();
        mem_init = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we: got %b expected 0", mem_we); miscompares++; end
        reset = 1'b0;
        #1;
        vectors++; if (empty !== 1'b1) begin $display("FAIL reset_empty: got %b expected 1", empty); miscompares++; end
        vectors++; if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b expected 0", stall); miscompares++; end
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we_after: got %b expected 0", mem_we); miscompares++; end
        cyc();
    endtask

    task automatic test_single_store();
        set(1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
        #1;
        vectors++; if (stall !== 1'b0) begin $display("FAIL single_stall: got %b expected 0", stall); miscompares++; end
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL single_we_accept_cycle: got %b expected 0", mem_we); miscompares++; end
        cyc();
        set(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        vectors++; if (mem_we !== 1'b1) begin $display("FAIL single_we: got %b expected 1", mem_we); miscompares++; end
        vectors++; if (mem_a !== 32'd5) begin $display("FAIL single_addr: got %h expected 5", mem_a); miscompares++; end
        vectors++; if (mem_wd !== 32'hDEAD_BEEF) begin $display("FAIL single_data: got %h expected deadbeef", mem_wd); miscompares++; end
        vectors++; if (empty !== 1'b0) begin $display("FAIL single_not_empty: got %b expected 0", empty); miscompares++; end
        cyc();
        vectors++; if (empty !== 1'b1) begin $display("FAIL single_empty_after: got %b expected 1", empty); miscompares++; end
        vectors++; if (mem[5] !== 32'hDEAD_BEEF) begin $display("FAIL single_mem5: got %h expected deadbeef", mem[5]); miscompares++; end
    endtask

    task automatic test_forward_youngest();
        set(1'b1, 1'b1, 32'd7, 32'h11);
        #1;
        vectors++; if (cpu_rd !== 32'hA000_0007) begin $display("FAIL fwd_pre_state: got %h expected a0000007", cpu_rd); miscompares++; end
        cyc();
        set(1'b1, 1'b1, 32'd7, 32'h22);
        #1;
        vectors++; if (cpu_rd !== 32'h11) begin $display("FAIL fwd_first: got %h expected 11", cpu_rd); miscompares++; end
        cyc();
        set(1'b0, 1'b1, 32'd7, 32'd0);
        #1;
        vectors++; if (cpu_rd !== 32'h22) begin $display("FAIL fwd_youngest: got %h expected 22", cpu_rd); miscompares++; end
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL fwd_load_priority: got %b expected 0", mem_we); miscompares++; end
        cyc();
        set(1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        cyc();
        cyc();
        vectors++; if (empty !== 1'b1) begin $display("FAIL fwd_empty: got %b expected 1", empty); miscompares++; end
        vectors++; if (mem[7] !== 32'h22) begin $display("FAIL fwd_mem7: got %h expected 22", mem[7]); miscompares++; end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 4; i++) begin
            set(1'b1, 1'b1, 32'(20 + i), 32'(32'h100 + i));
            #1;
            vectors++; if (stall !== 1'b0) begin $display("FAIL full_fill_stall%0d: got %b expected 0", i, stall); miscompares++; end
            cyc();
        end
        set(1'b1, 1'b1, 32'd24, 32'h124);
        #1;
        vectors++; if (stall !== 1'b1) begin $display("FAIL full_stall: got %b expected 1", stall); miscompares++; end
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL full_no_drain: got %b expected 0", mem_we); miscompares++; end
        cyc();
        vectors++; if (stall !== 1'b1) begin $display("FAIL full_stall_held: got %b expected 1", stall); miscompares++; end
        set(1'b1, 1'b0, 32'd24, 32'h124);
        #1;
        vectors++; if (stall !== 1'b0) begin $display("FAIL full_push_pop_stall: got %b expected 0", stall); miscompares++; end
        vectors++; if (mem_we !== 1'b1) begin $display("FAIL full_push_pop_we: got %b expected 1", mem_we); miscompares++; end
        vectors++; if (mem_a !== 32'd20) begin $display("FAIL full_push_pop_addr: got %h expected 14", mem_a); miscompares++; end
        vectors++; if (mem_wd !== 32'h100) begin $display("FAIL full_push_pop_data: got %h expected 100", mem_wd); miscompares++; end
        cyc();
        set(1'b1, 1'b1, 32'd25, 32'h125);
        #1;
        vectors++; if (stall !== 1'b1) begin $display("FAIL full_count_still4: got %b expected 1", stall); miscompares++; end
        set(1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        cyc();
        cyc();
        cyc();
        vectors++; if (empty !== 1'b1) begin $display("FAIL full_drained_empty: got %b expected 1", empty); miscompares++; end
        vectors++; if (mem[20] !== 32'h100) begin $display("FAIL full_mem20: got %h expected 100", mem[20]); miscompares++; end
        vectors++; if (mem[23] !== 32'h103) begin $display("FAIL full_mem23: got %h expected 103", mem[23]); miscompares++; end
        vectors++; if (mem[24] !== 32'h124) begin $display("FAIL full_mem24: got %h expected 124", mem[24]); miscompares++; end
        vectors++; if (mem[25] !== 32'hA000_0019) begin $display("FAIL full_mem25_untouched: got %h expected a0000019", mem[25]); miscompares++; end
    endtask

    task automatic test_load_miss();
        set(1'b1, 1'b1, 32'd30, 32'h30);
        cyc();
        set(1'b1, 1'b1, 32'd31, 32'h31);
        cyc();
        set(1'b0, 1'b1, 32'd9, 32'd0);
        #1;
        vectors++; if (mem_a !== 32'd9) begin $display("FAIL miss_addr: got %h expected 9", mem_a); miscompares++; end
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL miss_we: got %b expected 0", mem_we); miscompares++; end
        vectors++; if (cpu_rd !== 32'hA000_0009) begin $display("FAIL miss_rd: got %h expected a0000009", cpu_rd); miscompares++; end
        cyc();
        cyc();
        vectors++; if (empty !== 1'b0) begin $display("FAIL miss_pending: got %b expected 0", empty); miscompares++; end
        set(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        vectors++; if (mem_a !== 32'd30 || mem_we !== 1'b1) begin $display("FAIL miss_drain0: got a=%h we=%b expected a=1e we=1", mem_a, mem_we); miscompares++; end
        cyc();
        vectors++; if (mem_a !== 32'd31 || mem_we !== 1'b1) begin $display("FAIL miss_drain1: got a=%h we=%b expected a=1f we=1", mem_a, mem_we); miscompares++; end
        cyc();
        vectors++; if (empty !== 1'b1 || mem_we !== 1'b0) begin $display("FAIL miss_drained: got empty=%b we=%b expected empty=1 we=0", empty, mem_we); miscompares++; end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            set(1'b1, 1'b0, 32'(i), 32'(i * 3));
            #1;
            vectors++; if (stall !== 1'b0) begin $display("FAIL wrap_stall%0d: got %b expected 0", i, stall); miscompares++; end
            cyc();
        end
        set(1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        vectors++; if (empty !== 1'b1) begin $display("FAIL wrap_empty: got %b expected 1", empty); miscompares++; end
        for (int i = 0; i < 10; i++) begin
            vectors++; if (mem[i] !== 32'(i * 3)) begin $display("FAIL wrap_mem%0d: got %h expected %h", i, mem[i], 32'(i * 3)); miscompares++; end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set(1'b1, 1'b1, 32'(50 + i), 32'(32'h50 + i));
            cyc();
        end
        vectors++; if (empty !== 1'b0) begin $display("FAIL rmid_pending: got %b expected 0", empty); miscompares++; end
        reset = 1'b1;
        set(1'b1, 1'b0, 32'd60, 32'h60);
        #1;
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL rmid_we_during: got %b expected 0", mem_we); miscompares++; end
        vectors++; if (stall !== 1'b0) begin $display("FAIL rmid_stall_during: got %b expected 0", stall); miscompares++; end
        cyc();
        reset = 1'b0;
        set(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        vectors++; if (empty !== 1'b1) begin $display("FAIL rmid_empty: got %b expected 1", empty); miscompares++; end
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL rmid_we_after: got %b expected 0", mem_we); miscompares++; end
        cyc();
        cyc();
        cyc();
        vectors++; if (mem[50] !== 32'hA000_0032) begin $display("FAIL rmid_mem50: got %h expected a0000032", mem[50]); miscompares++; end
        vectors++; if (mem[51] !== 32'hA000_0033) begin $display("FAIL rmid_mem51: got %h expected a0000033", mem[51]); miscompares++; end
        vectors++; if (mem[52] !== 32'hA000_0034) begin $display("FAIL rmid_mem52: got %h expected a0000034", mem[52]); miscompares++; end
        vectors++; if (mem[60] !== 32'hA000_003C) begin $display("FAIL rmid_mem60: got %h expected a000003c", mem[60]); miscompares++; end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mem_init    = 1'b0;
        reset       = 1'b1;
        set(1'b0, 1'b0, 32'd0, 32'd0);
        test_reset();
        test_single_store();
        test_forward_youngest();
        test_full_stall();
        test_load_miss();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
